fetch_inst_buffer: RTL and testbench

// - Decoupling queue between FetchStage2 and Decode. Accepts up to 4 valid fetch packets per cycle
//   (instruction, pc, targetAddr, ctiqTag, prediction) and presents up to 4 oldest to Decode in order.
// - Absorbs Decode back-pressure; throttles fetch via stallFetch_o; cleared on pipeline flush.

---
 rtl/fetch_inst_buffer.sv | 143 ++++++++++++++
 tb/tb_fetch_inst_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer
//   Queue between FetchStage2 and Decode. Each cycle it accepts up to
//   FETCH_WIDTH packets and offers the DECODE_WIDTH oldest packets to Decode,
//   in program order. It absorbs Decode back-pressure, throttles fetch through
//   stallFetch_o, and empties on a pipeline flush.
//
//   Optional build macro: FETCH_IBUF_PERF_EN
//     When defined, the block adds the stallCycles_o port. This is a
//     saturating count of cycles in which fetch offered a bundle while the
//     buffer was stalling it. Only reset clears the count.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   flush_i        synchronous flush; discards the same-cycle push and pop
//   fs2Ready_i     FetchStage2 bundle valid
//   instValid_i    per-slot valid; only the leading run of ones from slot 0 counts
//   instPacket_i   FETCH_WIDTH packets, slot i at [(i+1)*PKT_W-1 : i*PKT_W]
//   decodeReady_i  Decode consumes the offered packets this cycle
//   instValid_o    per output slot valid
//   instPacket_o   packets head+0 .. head+DECODE_WIDTH-1, same slot packing
//   count_o        current occupancy
//   stallFetch_o   fewer than FETCH_WIDTH free entries
//   stallCycles_o  (FETCH_IBUF_PERF_EN only) stalled-fetch cycle counter
module fetch_inst_buffer #(
  parameter int DEPTH        = 16,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int PKT_W        = 133
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            fs2Ready_i,
  input  logic [FETCH_WIDTH-1:0]          instValid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0]    instPacket_i,
  input  logic                            decodeReady_i,
  output logic [DECODE_WIDTH-1:0]         instValid_o,
  output logic [DECODE_WIDTH*PKT_W-1:0]   instPacket_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            stallFetch_o
`ifdef FETCH_IBUF_PERF_EN
  ,
  output logic [31:0]                     stallCycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_WIDTH);
  localparam logic [CNT_W-1:0] DEC_C   = CNT_W'(DECODE_WIDTH);

  logic [PKT_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             run;
  logic [CNT_W-1:0] enqN;
  logic [CNT_W-1:0] enqAmt;
  logic [CNT_W-1:0] deqN;
  logic [CNT_W:0]   countNext;
  logic             push;

  // The stall decision depends only on the registered count. This keeps the
  // fetch throttle off the Decode ready path.
  assign stallFetch_o = (DEPTH_C - count) < FETCH_C;
  assign count_o      = count;
  assign push         = fs2Ready_i & ~stallFetch_o & ~flush_i;

  // Enqueue count: length of the unbroken run of valid slots starting at slot 0.
  always_comb begin
    enqN = '0;
    run  = 1'b1;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      run = run & instValid_i[k];
      if (run) enqN = enqN + 1'b1;
    end
  end

  always_comb begin
    enqAmt = push ? enqN : '0;
    deqN   = '0;
    if (decodeReady_i && !flush_i) deqN = (count < DEC_C) ? count : DEC_C;
    countNext = {1'b0, count} + {1'b0, enqAmt} - {1'b0, deqN};
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deqN[PTR_W-1:0];
      tail  <= tail + enqAmt[PTR_W-1:0];
      count <= countNext[CNT_W-1:0];
    end
  end

  // Packet storage is data only and is never reset. Validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (CNT_W'(k) < enqN)
          storage[tail + PTR_W'(k)] <= instPacket_i[k*PKT_W +: PKT_W];
      end
    end
  end

  // Combinational read of the oldest entries. Pointer addition wraps, so a
  // run that crosses DEPTH-1 -> 0 still comes out in program order.
  always_comb begin
    instValid_o  = '0;
    instPacket_o = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      instValid_o[i]                 = (count > CNT_W'(i)) & ~flush_i;
      instPacket_o[i*PKT_W +: PKT_W] = storage[head + PTR_W'(i)];
    end
  end

  // Occupancy must stay within 0..DEPTH. An underflow wraps to a large value,
  // so a single bound check catches both overflow and underflow.
  always_ff @(posedge clk) begin
    if (reset && !flush_i)
      assert (countNext <= (CNT_W+1)'(DEPTH));
  end

`ifdef FETCH_IBUF_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stallCycles_o <= '0;
    else if (fs2Ready_i && stallFetch_o && !flush_i && (stallCycles_o != 32'hFFFF_FFFF))
      stallCycles_o <= stallCycles_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_inst_buffer.sv
module tb_fetch_inst_buffer;

  localparam int PKT_W = 133;
  localparam int FW    = 4;
  localparam int DW    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush_i;
  logic                  fs2Ready_i;
  logic [FW-1:0]         instValid_i;
  logic [FW*PKT_W-1:0]   instPacket_i;
  logic                  decodeReady_i;
  logic [DW-1:0]         instValid_o;
  logic [DW*PKT_W-1:0]   instPacket_o;
  logic [4:0]            count_o;
  logic                  stallFetch_o;
`ifdef FETCH_IBUF_PERF_EN
  logic [31:0]           stallCycles_o;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  fetch_inst_buffer #(.DEPTH(16), .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .PKT_W(PKT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .fs2Ready_i    (fs2Ready_i),
    .instValid_i   (instValid_i),
    .instPacket_i  (instPacket_i),
    .decodeReady_i (decodeReady_i),
    .instValid_o   (instValid_o),
    .instPacket_o  (instPacket_o),
    .count_o       (count_o),
    .stallFetch_o  (stallFetch_o)
`ifdef FETCH_IBUF_PERF_EN
    ,
    .stallCycles_o (stallCycles_o)
`endif
  );

  always #5 clk = ~clk;

  // Packet = {tag, ~pc, pc}. Every field is derived from the pc, so a
  // misrouted packet never matches its expected value.
  function automatic logic [PKT_W-1:0] mkPkt(input logic [63:0] pc);
    mkPkt = {pc[4:0] ^ 5'h15, ~pc, pc};
  endfunction

  task automatic checkVal(input string tag, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drivePush(input logic [FW-1:0] v, input logic [63:0] base);
    fs2Ready_i  = 1'b1;
    instValid_i = v;
    for (int k = 0; k < FW; k++)
      instPacket_i[k*PKT_W +: PKT_W] = mkPkt(base + 64'(8*k));
  endtask

  task automatic noPush;
    fs2Ready_i  = 1'b0;
    instValid_i = '0;
  endtask

  function automatic logic [PKT_W-1:0] outSlot(input int i);
    outSlot = instPacket_o[i*PKT_W +: PKT_W];
  endfunction

  initial begin
    reset = 1'b0; flush_i = 1'b0; fs2Ready_i = 1'b0; instValid_i = '0;
    instPacket_i = '0; decodeReady_i = 1'b0;
    #12;
    checkVal("rst_count", PKT_W'(count_o), PKT_W'(0));
    checkVal("rst_valid", PKT_W'(instValid_o), PKT_W'(0));
    checkVal("rst_stall", PKT_W'(stallFetch_o), PKT_W'(0));
    reset = 1'b1;
    tick();

    // Fill to full, then attempt a push that must be dropped.
    for (int p = 0; p < 4; p++) begin
      drivePush(4'b1111, 64'h1000 + 64'(32*p));
      tick();
      checkVal($sformatf("fill_count%0d", p), PKT_W'(count_o), PKT_W'(4*(p+1)));
      checkVal($sformatf("fill_stall%0d", p), PKT_W'(stallFetch_o), PKT_W'(p == 3));
    end
    drivePush(4'b1111, 64'h2000);
    tick();
    checkVal("drop_count", PKT_W'(count_o), PKT_W'(16));
    checkVal("full_valid", PKT_W'(instValid_o), PKT_W'(4'hF));
    checkVal("full_slot0", outSlot(0), mkPkt(64'h1000));
    checkVal("full_slot3", outSlot(3), mkPkt(64'h1018));
`ifdef FETCH_IBUF_PERF_EN
    checkVal("perf_stall", PKT_W'(stallCycles_o), PKT_W'(1));
`endif
    noPush();
    decodeReady_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checkVal($sformatf("drain_head%0d", j), outSlot(0), mkPkt(64'h1000 + 64'(32*j)));
      tick();
    end
    checkVal("drain_count", PKT_W'(count_o), PKT_W'(0));
    checkVal("drain_valid", PKT_W'(instValid_o), PKT_W'(0));
    decodeReady_i = 1'b0;

    // Prefix handling: only the leading run of valid slots is taken.
    drivePush(4'b0011, 64'h3000);
    tick();
    checkVal("pfx_count_a", PKT_W'(count_o), PKT_W'(2));
    drivePush(4'b0101, 64'h4000);
    tick();
    noPush();
    checkVal("pfx_count_b", PKT_W'(count_o), PKT_W'(3));
    checkVal("pfx_valid", PKT_W'(instValid_o), PKT_W'(4'b0111));
    checkVal("pfx_slot0", outSlot(0), mkPkt(64'h3000));
    checkVal("pfx_slot1", outSlot(1), mkPkt(64'h3008));
    checkVal("pfx_slot2", outSlot(2), mkPkt(64'h4000));
    decodeReady_i = 1'b1;
    tick();
    decodeReady_i = 1'b0;
    checkVal("pfx_empty", PKT_W'(count_o), PKT_W'(0));

    // Wrap: head and tail are at 3. Advance both to 14 with 11 entries.
    drivePush(4'b1111, 64'h9000); tick();
    drivePush(4'b1111, 64'h9000); tick();
    drivePush(4'b0111, 64'h9000); tick();
    noPush();
    checkVal("adv_count", PKT_W'(count_o), PKT_W'(11));
    decodeReady_i = 1'b1;
    tick(); tick(); tick();
    decodeReady_i = 1'b0;
    checkVal("adv_empty", PKT_W'(count_o), PKT_W'(0));
    drivePush(4'b1111, 64'h5000);
    tick();
    noPush();
    checkVal("wrap_count", PKT_W'(count_o), PKT_W'(4));
    for (int i = 0; i < 4; i++)
      checkVal($sformatf("wrap_slot%0d", i), outSlot(i), mkPkt(64'h5000 + 64'(8*i)));
    decodeReady_i = 1'b1;
    tick();
    decodeReady_i = 1'b0;

    // Concurrent push and pop at count 8.
    drivePush(4'b1111, 64'h6000); tick();
    drivePush(4'b1111, 64'h6020); tick();
    checkVal("conc_pre_count", PKT_W'(count_o), PKT_W'(8));
    checkVal("conc_pre_slot0", outSlot(0), mkPkt(64'h6000));
    drivePush(4'b1111, 64'h6040);
    decodeReady_i = 1'b1;
    tick();
    noPush();
    decodeReady_i = 1'b0;
    checkVal("conc_count", PKT_W'(count_o), PKT_W'(8));
    for (int i = 0; i < 4; i++)
      checkVal($sformatf("conc_slot%0d", i), outSlot(i), mkPkt(64'h6020 + 64'(8*i)));

    // Flush at count 10 with a push and a pop in the same cycle.
    drivePush(4'b0011, 64'h7000);
    tick();
    checkVal("fl_pre_count", PKT_W'(count_o), PKT_W'(10));
    drivePush(4'b1111, 64'h7100);
    decodeReady_i = 1'b1;
    flush_i = 1'b1;
    #1;
    checkVal("fl_valid_same", PKT_W'(instValid_o), PKT_W'(0));
    tick();
    flush_i = 1'b0;
    noPush();
    decodeReady_i = 1'b0;
    checkVal("fl_count", PKT_W'(count_o), PKT_W'(0));
    checkVal("fl_valid", PKT_W'(instValid_o), PKT_W'(0));
    checkVal("fl_stall", PKT_W'(stallFetch_o), PKT_W'(0));
`ifdef FETCH_IBUF_PERF_EN
    checkVal("perf_flush", PKT_W'(stallCycles_o), PKT_W'(1));
`endif

    // Asynchronous reset mid-run at count 9.
    drivePush(4'b1111, 64'h8000); tick();
    drivePush(4'b1111, 64'h8020); tick();
    drivePush(4'b0001, 64'h8040); tick();
    noPush();
    checkVal("mid_count", PKT_W'(count_o), PKT_W'(9));
    #2;
    reset = 1'b0;
    #1;
    checkVal("arst_count", PKT_W'(count_o), PKT_W'(0));
    checkVal("arst_valid", PKT_W'(instValid_o), PKT_W'(0));
    checkVal("arst_stall", PKT_W'(stallFetch_o), PKT_W'(0));
    tick();
    reset = 1'b1;
    tick();
    checkVal("post_rst_count", PKT_W'(count_o), PKT_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
